// File: rtl/beat_serializer.sv
// Wide-to-narrow stream serializer: one IN_W word in, IN_W/OUT_W OUT_W-bit beats out, LSB slice first.
// Optional BEAT_SERIALIZER_LEN_EN adds inLen to shorten a word to inLen+1 beats.
module beat_serializer #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inValid,
  output logic             inReady,
  input  logic [IN_W-1:0]  dIn,
`ifdef BEAT_SERIALIZER_LEN_EN
  input  logic [$clog2((OUT_W > 0) ? (IN_W / OUT_W) : 2)-1:0] inLen,
`endif
  output logic             outValid,
  input  logic             outReady,
  output logic [OUT_W-1:0] dOut,
  output logic             outLast
);

  localparam int NUM_BEATS = (OUT_W > 0) ? (IN_W / OUT_W) : 2;
  localparam int CNT_W     = $clog2(NUM_BEATS);

  if (OUT_W < 1) begin : gBadOutW
    $error("%m: OUT_W must be at least 1");
  end
  if ((OUT_W > 0) && (IN_W % OUT_W != 0)) begin : gBadRatio
    $error("%m: IN_W must be an integer multiple of OUT_W");
  end
  if (NUM_BEATS < 2) begin : gBadBeats
    $error("%m: IN_W/OUT_W must be at least 2");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] finalCnt;
  logic [CNT_W-1:0] loadLen;
  logic [CNT_W-1:0] cntNext;
  logic [IN_W-1:0]  shiftReg;
  logic [IN_W-1:0]  shifted;
  logic             xferOut;
  logic             lastXfer;
  logic             load;

  assign xferOut  = outValid && outReady;
  assign lastXfer = xferOut && outLast;
  // The last beat leaving frees the slot in the same cycle, so words stream without a bubble.
  assign inReady  = rstn && ((state == IDLE) || lastXfer);
  assign load     = inValid && inReady;
  assign cntNext  = cnt + CNT_W'(1);
  assign shifted  = shiftReg >> OUT_W;

`ifdef BEAT_SERIALIZER_LEN_EN
  always_comb begin
    loadLen = inLen;
    if (int'(inLen) > NUM_BEATS - 1) loadLen = CNT_W'(NUM_BEATS - 1);
  end
`else
  assign loadLen = CNT_W'(NUM_BEATS - 1);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      finalCnt <= '0;
      outValid <= 1'b0;
      outLast  <= 1'b0;
    end else if (load) begin
      state    <= SEND;
      cnt      <= '0;
      finalCnt <= loadLen;
      outValid <= 1'b1;
      outLast  <= (loadLen == '0);
    end else if (lastXfer) begin
      state    <= IDLE;
      cnt      <= '0;
      outValid <= 1'b0;
      outLast  <= 1'b0;
    end else if (xferOut) begin
      cnt      <= cntNext;
      outLast  <= (cntNext == finalCnt);
    end
  end

  // Payload registers carry no reset; their contents are qualified by outValid.
  always_ff @(posedge clk) begin
    if (load) begin
      shiftReg <= dIn;
      dOut     <= dIn[OUT_W-1:0];
    end else if (xferOut && !outLast) begin
      shiftReg <= shifted;
      dOut     <= shifted[OUT_W-1:0];
    end
  end

endmodule

// File: tb/tb_beat_serializer.sv
// Directed bench for beat_serializer (IN_W=32, OUT_W=8): basic, back-to-back, stall, reset, idle gap.
module tb_beat_serializer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        inValid;
  logic        inReady;
  logic [31:0] dIn;
  logic        outValid;
  logic        outReady;
  logic [7:0]  dOut;
  logic        outLast;
`ifdef BEAT_SERIALIZER_LEN_EN
  logic [1:0]  inLen;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  beat_serializer #(.IN_W(32), .OUT_W(8)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .inValid  (inValid),
    .inReady  (inReady),
    .dIn      (dIn),
`ifdef BEAT_SERIALIZER_LEN_EN
    .inLen    (inLen),
`endif
    .outValid (outValid),
    .outReady (outReady),
    .dOut     (dOut),
    .outLast  (outLast)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [7:0] expD, input logic expLast, input logic expRdy);
    chk({tag, ".outValid"}, 32'(outValid), 32'd1);
    chk({tag, ".dOut"},     32'(dOut),     32'(expD));
    chk({tag, ".outLast"},  32'(outLast),  32'(expLast));
    chk({tag, ".inReady"},  32'(inReady),  32'(expRdy));
  endtask

  task automatic idle(input string tag);
    chk({tag, ".outValid"}, 32'(outValid), 32'd0);
    chk({tag, ".outLast"},  32'(outLast),  32'd0);
    chk({tag, ".inReady"},  32'(inReady),  32'd1);
  endtask

  initial begin
    rstn     = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    dIn      = '0;
`ifdef BEAT_SERIALIZER_LEN_EN
    inLen    = 2'd3;
`endif
    #1;
    chk("rst.outValid", 32'(outValid), 32'd0);
    chk("rst.outLast",  32'(outLast),  32'd0);
    chk("rst.inReady",  32'(inReady),  32'd0);
    tick();
    tick();
    rstn = 1'b1;
    #1;
    idle("rel");

    // Basic word with outReady held high
    dIn = 32'hA1B2C3D4; inValid = 1'b1; outReady = 1'b1;
    tick(); inValid = 1'b0;
    beat("b0", 8'hD4, 1'b0, 1'b0);
    tick(); beat("b1", 8'hC3, 1'b0, 1'b0);
    tick(); beat("b2", 8'hB2, 1'b0, 1'b0);
    tick(); beat("b3", 8'hA1, 1'b1, 1'b1);
    tick(); idle("bEnd");

    // Back-to-back words, second accepted on the last beat of the first
    dIn = 32'h11223344; inValid = 1'b1;
    tick(); beat("bb0", 8'h44, 1'b0, 1'b0);
    dIn = 32'h55667788;
    tick(); beat("bb1", 8'h33, 1'b0, 1'b0);
    tick(); beat("bb2", 8'h22, 1'b0, 1'b0);
    tick(); beat("bb3", 8'h11, 1'b1, 1'b1);
    tick(); beat("bb4", 8'h88, 1'b0, 1'b0);
    inValid = 1'b0;
    tick(); beat("bb5", 8'h77, 1'b0, 1'b0);
    tick(); beat("bb6", 8'h66, 1'b0, 1'b0);
    tick(); beat("bb7", 8'h55, 1'b1, 1'b1);
    tick(); idle("bbEnd");

    // Backpressure during the C3 beat; a pending input must not be taken
    dIn = 32'hA1B2C3D4; inValid = 1'b1;
    tick(); beat("bp0", 8'hD4, 1'b0, 1'b0);
    dIn = 32'h99999999;
    tick(); beat("bp1", 8'hC3, 1'b0, 1'b0);
    outReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); beat("bpHold", 8'hC3, 1'b0, 1'b0);
    end
    outReady = 1'b1; inValid = 1'b0;
    tick(); beat("bp2", 8'hB2, 1'b0, 1'b0);
    tick(); beat("bp3", 8'hA1, 1'b1, 1'b1);
    tick(); idle("bpEnd");

    // Reset asserted mid-word discards the word at once
    dIn = 32'hA1B2C3D4; inValid = 1'b1;
    tick(); inValid = 1'b0;
    beat("rm0", 8'hD4, 1'b0, 1'b0);
    tick(); beat("rm1", 8'hC3, 1'b0, 1'b0);
    tick(); beat("rm2", 8'hB2, 1'b0, 1'b0);
    rstn = 1'b0;
    #1;
    chk("rmAsync.outValid", 32'(outValid), 32'd0);
    chk("rmAsync.outLast",  32'(outLast),  32'd0);
    chk("rmAsync.inReady",  32'(inReady),  32'd0);
    tick();
    rstn = 1'b1;
    #1;
    idle("rmRel");
    dIn = 32'hDEADBEEF; inValid = 1'b1;
    tick(); inValid = 1'b0;
    beat("rn0", 8'hEF, 1'b0, 1'b0);
    tick(); beat("rn1", 8'hBE, 1'b0, 1'b0);
    tick(); beat("rn2", 8'hAD, 1'b0, 1'b0);
    tick(); beat("rn3", 8'hDE, 1'b1, 1'b1);
    tick(); idle("rnEnd");

    // One word followed by an idle gap
    dIn = 32'h01020304; inValid = 1'b1;
    tick(); inValid = 1'b0;
    beat("ig0", 8'h04, 1'b0, 1'b0);
    tick(); beat("ig1", 8'h03, 1'b0, 1'b0);
    tick(); beat("ig2", 8'h02, 1'b0, 1'b0);
    tick(); beat("ig3", 8'h01, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(); idle("igGap");
    end

`ifdef BEAT_SERIALIZER_LEN_EN
    // Shortened words
    dIn = 32'hA1B2C3D4; inLen = 2'd1; inValid = 1'b1;
    tick(); inValid = 1'b0;
    beat("ln0", 8'hD4, 1'b0, 1'b0);
    tick(); beat("ln1", 8'hC3, 1'b1, 1'b1);
    tick(); idle("lnEnd");
    inLen = 2'd0; inValid = 1'b1;
    tick(); inValid = 1'b0;
    beat("lz0", 8'hD4, 1'b1, 1'b1);
    tick(); idle("lzEnd");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
